pipe_slice_skid: RTL and testbench

- Parametrised elastic pipeline register for the FP adder datapath. Generalises the single-bit clearable flop to a WIDTH-bit bus and a chain of STAGES registered slices.
- Each slice carries a valid/ready handshake and a 2-entry skid buffer. The chain sustains one beat per cycle under backpressure, with every output, including In_ready, driven from a register.
- Sits between adder stages: align, add, normalise, round.
- Adds synchronous flush and an occupancy count.

---
 rtl/pipe_slice_skid_if.sv | 24 ++
 rtl/pipe_slice_skid.sv | 117 +++++++++++
 tb/tb_pipe_slice_skid.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_slice_skid_if.sv
// rtl/pipe_slice_skid_if.sv - upstream/downstream handshake bundle and occupancy for pipe_slice_skid
interface pipe_slice_skid_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(2*STAGES+1)
);
    logic             In_valid;
    logic [WIDTH-1:0] In_data;
    logic             In_ready;
    logic             Out_valid;
    logic [WIDTH-1:0] Out_data;
    logic             Out_ready;
    logic [CW-1:0]    Count;

    modport slave (
        input  In_valid, In_data, Out_ready,
        output In_ready, Out_valid, Out_data, Count
    );

    modport master (
        output In_valid, In_data, Out_ready,
        input  In_ready, Out_valid, Out_data, Count
    );
endinterface

// File: rtl/pipe_slice_skid.sv
// rtl/pipe_slice_skid.sv - chain of STAGES registered valid/ready slices, each with a 2-entry skid buffer
module pipe_slice_skid #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(2*STAGES+1)
) (
    input  logic             Clk,
    input  logic             Clear_n,
    input  logic             Flush,
    pipe_slice_skid_if.slave bus
);
    // Bit 0 is the main register valid, bit 1 the skid register valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } slice_state_t;

    logic [STAGES:0]  w_valid;
    logic [STAGES:0]  w_ready;
    logic [WIDTH-1:0] w_data [STAGES+1];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

    assign w_valid[0]      = bus.In_valid;
    assign w_data[0]       = bus.In_data;
    assign w_ready[STAGES] = bus.Out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        slice_state_t     r_state;
        slice_state_t     w_state_nxt;
        logic [WIDTH-1:0] r_main;
        logic [WIDTH-1:0] r_skid;
        logic [WIDTH-1:0] w_main_nxt;
        logic [WIDTH-1:0] w_skid_nxt;
        logic             r_ready;
        logic             w_in;
        logic             w_out;

        assign w_in  = w_valid[g] && r_ready;
        assign w_out = r_state[0] && w_ready[g+1];

        always_comb begin
            w_state_nxt = r_state;
            w_main_nxt  = r_main;
            w_skid_nxt  = r_skid;
            case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_data[g];
                    end
                end
                ST_ONE: begin
                    if (w_in && w_out) begin
                        w_main_nxt = w_data[g];
                    end else if (w_in) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = w_data[g];
                    end else if (w_out) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
            // Flush only drops valid bits; payload registers keep whatever they were loaded with.
            if (Flush) begin
                w_state_nxt = ST_EMPTY;
            end
        end

        always_ff @(posedge Clk or negedge Clear_n) begin
            if (!Clear_n) begin
                r_state <= ST_EMPTY;
                r_main  <= '0;
                r_skid  <= '0;
                r_ready <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_main  <= w_main_nxt;
                r_skid  <= w_skid_nxt;
                r_ready <= (w_state_nxt != ST_TWO);
            end
        end

        assign w_valid[g+1] = r_state[0];
        assign w_data[g+1]  = r_main;
        assign w_ready[g]   = r_ready;
    end

    assign w_in_xfer  = bus.In_valid && w_ready[0];
    assign w_out_xfer = w_valid[STAGES] && bus.Out_ready;

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            r_count <= '0;
        end else if (Flush) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign bus.In_ready  = w_ready[0];
    assign bus.Out_valid = w_valid[STAGES];
    assign bus.Out_data  = w_data[STAGES];
    assign bus.Count     = r_count;
endmodule

// File: tb/tb_pipe_slice_skid.sv
// tb/tb_pipe_slice_skid.sv - self-checking bench for pipe_slice_skid against a per-slice queue model
module tb_pipe_slice_skid;
    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int CW     = $clog2(2*STAGES+1);
    localparam int DEPTH  = 2;

    logic Clk     = 1'b0;
    logic Clear_n = 1'b0;
    logic Flush   = 1'b0;

    pipe_slice_skid_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

    pipe_slice_skid #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .Clk     (Clk),
        .Clear_n (Clear_n),
        .Flush   (Flush),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each slice is a FIFO of up to DEPTH beats; a slice takes a beat when it had room before the edge.
    logic [WIDTH-1:0] m_q [STAGES][DEPTH];
    int               m_n [STAGES];
    bit               m_live;

    function automatic bit m_rdy(input int i);
        return m_live && (m_n[i] < DEPTH);
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < STAGES; i++) s += m_n[i];
        return s;
    endfunction

    task automatic m_pop(input int i, output logic [WIDTH-1:0] v);
        v = m_q[i][0];
        m_q[i][0] = m_q[i][1];
        m_n[i]--;
    endtask

    task automatic m_push(input int i, input logic [WIDTH-1:0] v);
        m_q[i][m_n[i]] = v;
        m_n[i]++;
    endtask

    always @(posedge Clk or negedge Clear_n) begin : model
        bit               take_out;
        bit               take_in;
        bit               mv [STAGES];
        logic [WIDTH-1:0] v;
        if (!Clear_n) begin
            for (int i = 0; i < STAGES; i++) begin
                m_n[i] = 0;
                m_q[i][0] = '0;
                m_q[i][1] = '0;
            end
            m_live = 1'b0;
        end else if (Flush) begin
            for (int i = 0; i < STAGES; i++) m_n[i] = 0;
            m_live = 1'b1;
        end else begin
            take_out = (m_n[STAGES-1] > 0) && bus.Out_ready;
            for (int i = 0; i < STAGES; i++)
                mv[i] = (i < STAGES-1) ? ((m_n[i] > 0) && m_rdy(i+1)) : 1'b0;
            take_in = bus.In_valid && m_rdy(0);
            if (take_out) m_pop(STAGES-1, v);
            for (int i = STAGES-2; i >= 0; i--) begin
                if (mv[i]) begin
                    m_pop(i, v);
                    m_push(i+1, v);
                end
            end
            if (take_in) m_push(0, bus.In_data);
            m_live = 1'b1;
        end
    end

    always @(negedge Clk) begin : compare
        if (!Clear_n) begin
            check("rst_in_ready", {63'd0, bus.In_ready}, 64'd0);
            check("rst_out_valid", {63'd0, bus.Out_valid}, 64'd0);
            check("rst_out_data", 64'(bus.Out_data), 64'd0);
            check("rst_count", 64'(bus.Count), 64'd0);
        end else begin
            check("in_ready", {63'd0, bus.In_ready}, {63'd0, m_rdy(0)});
            check("out_valid", {63'd0, bus.Out_valid}, {63'd0, m_n[STAGES-1] > 0});
            check("count", 64'(bus.Count), 64'(m_total()));
            if (m_n[STAGES-1] > 0)
                check("out_data", 64'(bus.Out_data), 64'(m_q[STAGES-1][0]));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base, input int max_cyc, output int acc);
        acc = 0;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            bus.In_valid = 1'b1;
            bus.In_data  = base + WIDTH'(acc);
            if (bus.In_ready) acc++;
            step();
        end
        bus.In_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] got [$];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] exp_v;
    int acc, first_c, last_c, peak, drops, seen, sent, cyc;
    bit pending, hold, found;

    initial begin
        bus.In_valid  = 1'b0;
        bus.In_data   = '0;
        bus.Out_ready = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check("hold_rst_out_valid", {63'd0, bus.Out_valid}, 64'd0);
        check("hold_rst_out_data", 64'(bus.Out_data), 64'd0);
        check("hold_rst_in_ready", {63'd0, bus.In_ready}, 64'd0);
        check("hold_rst_count", 64'(bus.Count), 64'd0);

        step();
        Clear_n = 1'b1;
        #1;
        check("ready_before_first_edge", {63'd0, bus.In_ready}, 64'd0);
        step();
        check("ready_after_first_edge", {63'd0, bus.In_ready}, 64'd1);

        // Single beat latency through three slices
        bus.Out_ready = 1'b1;
        bus.In_valid  = 1'b1;
        bus.In_data   = 32'h3F80_0000;
        step();
        bus.In_valid = 1'b0;
        check("lat_count_t", 64'(bus.Count), 64'd1);
        check("lat_valid_t", {63'd0, bus.Out_valid}, 64'd0);
        step();
        check("lat_valid_t1", {63'd0, bus.Out_valid}, 64'd0);
        step();
        check("lat_valid_t2", {63'd0, bus.Out_valid}, 64'd1);
        check("lat_data_t2", 64'(bus.Out_data), 64'h3F80_0000);
        step();
        check("lat_valid_drained", {63'd0, bus.Out_valid}, 64'd0);
        check("lat_count_drained", 64'(bus.Count), 64'd0);

        // Streaming 16 beats
        got.delete();
        drops = 0; peak = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                bus.In_valid = 1'b1;
                bus.In_data  = WIDTH'(c);
                if (!bus.In_ready) drops++;
            end else begin
                bus.In_valid = 1'b0;
            end
            step();
            if (bus.Out_valid) begin
                got.push_back(bus.Out_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (int'(bus.Count) > peak) peak = int'(bus.Count);
        end
        check("stream_ready_drops", 64'(drops), 64'd0);
        check("stream_beats", 64'(got.size()), 64'd16);
        for (int i = 0; i < got.size(); i++) check("stream_order", 64'(got[i]), 64'(i));
        check("stream_consecutive", 64'(last_c - first_c), 64'd15);
        check("stream_peak_count", 64'(peak), 64'd3);

        // Backpressure: fill until In_ready drops
        bus.Out_ready = 1'b0;
        push_n(99, 32'h100, 20, acc);
        check("bp_accepted", 64'(acc), 64'd6);
        check("bp_count", 64'(bus.Count), 64'd6);
        check("bp_in_ready", {63'd0, bus.In_ready}, 64'd0);
        bus.Out_ready = 1'b1;
        got.delete();
        first_c = -1; last_c = -1;
        for (int c = 0; c < 12; c++) begin
            if (bus.Out_valid) begin
                got.push_back(bus.Out_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            step();
        end
        check("bp_drained", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size(); i++) check("bp_order", 64'(got[i]), 64'h100 + 64'(i));
        check("bp_consecutive", 64'(last_c - first_c), 64'd5);
        check("bp_ready_back", {63'd0, bus.In_ready}, 64'd1);

        // Flush with an input beat presented in the flush cycle
        bus.Out_ready = 1'b0;
        push_n(4, 32'h200, 10, acc);
        check("fl_count_before", 64'(bus.Count), 64'd4);
        Flush        = 1'b1;
        bus.In_valid = 1'b1;
        bus.In_data  = 32'hBAD0_BAD0;
        step();
        Flush        = 1'b0;
        bus.In_valid = 1'b0;
        check("fl_count", 64'(bus.Count), 64'd0);
        check("fl_out_valid", {63'd0, bus.Out_valid}, 64'd0);
        check("fl_in_ready", {63'd0, bus.In_ready}, 64'd1);
        bus.Out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.Out_valid) seen++;
        end
        check("fl_nothing_after", 64'(seen), 64'd0);

        // Asynchronous reset between edges with five beats held
        bus.Out_ready = 1'b0;
        push_n(5, 32'h300, 12, acc);
        check("ar_count_before", 64'(bus.Count), 64'd5);
        #2;
        Clear_n = 1'b0;
        #1;
        check("ar_out_valid", {63'd0, bus.Out_valid}, 64'd0);
        check("ar_out_data", 64'(bus.Out_data), 64'd0);
        check("ar_in_ready", {63'd0, bus.In_ready}, 64'd0);
        check("ar_count", 64'(bus.Count), 64'd0);
        @(negedge Clk);
        #1;
        Clear_n = 1'b1;
        step();
        bus.Out_ready = 1'b1;
        push_n(1, 32'hDEAD_BEEF, 5, acc);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus.Out_valid) begin
                found = 1'b1;
                check("ar_first_beat", 64'(bus.Out_data), 64'hDEAD_BEEF);
            end
            step();
        end
        if (!found) check("ar_first_beat_timeout", 64'd0, 64'd1);
        repeat (4) step();

        // Random stall: 1000 beats with 50% valid and 50% ready
        sb.delete();
        sent = 0; cyc = 0; pending = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!pending) begin
                bus.In_valid = ($urandom_range(0, 1) == 1) && (sent < 1000);
                bus.In_data  = $urandom;
            end
            bus.Out_ready = ($urandom_range(0, 1) == 1);
            if (bus.In_valid && bus.In_ready) begin
                sb.push_back(bus.In_data);
                sent++;
            end
            if (bus.Out_valid && bus.Out_ready) begin
                if (sb.size() == 0) check("rs_underflow", 64'd1, 64'd0);
                else begin
                    exp_v = sb.pop_front();
                    check("rs_order", 64'(bus.Out_data), 64'(exp_v));
                end
            end
            hold    = bus.Out_valid && !bus.Out_ready;
            hold_d  = bus.Out_data;
            pending = bus.In_valid && !bus.In_ready;
            step();
            cyc++;
            if (hold) begin
                check("rs_stall_valid", {63'd0, bus.Out_valid}, 64'd1);
                check("rs_stall_data", 64'(bus.Out_data), 64'(hold_d));
            end
        end
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            if (bus.Out_valid) begin
                exp_v = sb.pop_front();
                check("rs_drain_order", 64'(bus.Out_data), 64'(exp_v));
            end
            step();
        end
        check("rs_sent", 64'(sent), 64'd1000);
        check("rs_all_delivered", 64'(sb.size()), 64'd0);
        check("rs_final_count", 64'(bus.Count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
